// File: rtl/hue_sequencer.sv
// Hue sequencer: debounced push-button cycles the sequencing mode, and a step
// timer walks a 0-359 degree hue angle forward, fast, frozen or backward.
module hue_sequencer #(
  parameter int unsigned CLK_FREQUENCY   = 12000000,
  parameter int unsigned DEBOUNCE_CYCLES = 120000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn,
  output logic [8:0] hue_angle,
  output logic       hue_valid,
  output logic [1:0] mode
);

  localparam int unsigned STEP_SLOW = CLK_FREQUENCY / 360;
  localparam int unsigned STEP_FAST = CLK_FREQUENCY / 1440;
  localparam int unsigned TW        = $clog2(STEP_SLOW);
  localparam int unsigned DW        = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int unsigned HUE_W     = 9;
  localparam int unsigned HUE_MAX   = 359;

  typedef enum logic [1:0] {
    RUN_SLOW = 2'd0,
    RUN_FAST = 2'd1,
    HOLD     = 2'd2,
    REVERSE  = 2'd3
  } mode_e;

  logic             sync1_q, sync2_q;
  logic [DW-1:0]    db_cnt_q, db_cnt_d;
  logic             db_level_q, db_level_d;
  logic             db_level_dly_q;
  mode_e            mode_q, mode_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [HUE_W-1:0] hue_q, hue_d;
  logic             valid_q, valid_d;
  logic [TW-1:0]    step_last_c;
  logic             mode_adv_c;

  assign step_last_c = (mode_q == RUN_FAST) ? TW'(STEP_FAST - 1) : TW'(STEP_SLOW - 1);
  // Mode advances one edge after the debounced level rises, giving
  // DEBOUNCE_CYCLES+2 cycles from the first synchronizer sample.
  assign mode_adv_c  = db_level_q & ~db_level_dly_q;

  always_comb begin : next_state
    db_level_d = db_level_q;
    db_cnt_d   = '0;
    mode_d     = mode_q;
    timer_d    = timer_q;
    hue_d      = hue_q;
    valid_d    = 1'b0;

    if (sync2_q != db_level_q) begin
      if (db_cnt_q == DW'(DEBOUNCE_CYCLES - 1)) begin
        db_level_d = sync2_q;
      end else begin
        db_cnt_d = db_cnt_q + DW'(1);
      end
    end

    // A mode change takes priority over a coincident hue step.
    if (mode_adv_c) begin
      mode_d  = mode_e'(2'(mode_q) + 2'd1);
      timer_d = '0;
    end else if (mode_q == HOLD) begin
      timer_d = '0;
    end else if (timer_q == step_last_c) begin
      timer_d = '0;
      valid_d = 1'b1;
      if (mode_q == REVERSE) begin
        hue_d = (hue_q == HUE_W'(0)) ? HUE_W'(HUE_MAX) : hue_q - HUE_W'(1);
      end else begin
        hue_d = (hue_q == HUE_W'(HUE_MAX)) ? HUE_W'(0) : hue_q + HUE_W'(1);
      end
    end else begin
      timer_d = timer_q + TW'(1);
    end
  end

  always_ff @(posedge clk) begin : regs
    if (!rst_n) begin
      sync1_q        <= 1'b0;
      sync2_q        <= 1'b0;
      db_cnt_q       <= '0;
      db_level_q     <= 1'b0;
      db_level_dly_q <= 1'b0;
      mode_q         <= RUN_SLOW;
      timer_q        <= '0;
      hue_q          <= '0;
      valid_q        <= 1'b0;
    end else begin
      sync1_q        <= btn;
      sync2_q        <= sync1_q;
      db_cnt_q       <= db_cnt_d;
      db_level_q     <= db_level_d;
      db_level_dly_q <= db_level_q;
      mode_q         <= mode_d;
      timer_q        <= timer_d;
      hue_q          <= hue_d;
      valid_q        <= valid_d;
    end
  end

  assign hue_angle = hue_q;
  assign hue_valid = valid_q;
  assign mode      = mode_q;

endmodule

// File: tb/tb_hue_sequencer.sv
// Scoreboard bench for hue_sequencer: stimulus pushes expected hue steps
// (value and edge number), a negedge monitor pops them on each hue_valid.
module tb_hue_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       btn;
  logic [8:0] hue_angle;
  logic       hue_valid;
  logic [1:0] mode;

  int unsigned cyc   = 0;
  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  typedef struct {
    int unsigned hue;
    int unsigned edge_no;
  } exp_t;
  exp_t exp_q[$];

  int unsigned tb_hue;
  int unsigned next_step;
  int unsigned cur_mode;

  hue_sequencer #(
    .CLK_FREQUENCY  (2880),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn      (btn),
    .hue_angle(hue_angle),
    .hue_valid(hue_valid),
    .mode     (mode)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int unsigned n_of(input int unsigned m);
    return (m == 1) ? 2 : 8;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s @edge %0d: got %0d, expected %0d", name, cyc, act, exp_v);
    end
  endtask

  // Push every hue step the model predicts on edges strictly before limit.
  task automatic schedule(input int unsigned limit);
    exp_t e;
    while (cur_mode != 2 && next_step < limit) begin
      if (cur_mode == 3) tb_hue = (tb_hue == 0) ? 359 : tb_hue - 1;
      else               tb_hue = (tb_hue == 359) ? 0 : tb_hue + 1;
      e.hue     = tb_hue;
      e.edge_no = next_step;
      exp_q.push_back(e);
      next_step += n_of(cur_mode);
    end
  endtask

  task automatic wait_edge(input int unsigned target);
    while (cyc < target) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int unsigned n);
    int unsigned t;
    t = cyc + n;
    schedule(t + 1);
    wait_edge(t);
  endtask

  // Clean 6-sample press; mode must change exactly at p+7 (6 after first sample).
  // With align set, the change edge is placed on a would-be hue step.
  task automatic press(input int unsigned new_mode, input bit align);
    int unsigned p;
    int unsigned m;
    if (align && cur_mode != 2) begin
      while (((cyc + 7) % n_of(cur_mode)) != (next_step % n_of(cur_mode))) begin
        schedule(cyc + 2);
        @(posedge clk);
        #1;
      end
    end
    p = cyc;
    m = p + 7;
    schedule(m);
    btn = 1'b1;
    wait_edge(p + 6);
    chk("mode_before_latency", 32'(mode), cur_mode);
    btn = 1'b0;
    wait_edge(m);
    chk("mode_after_press", 32'(mode), new_mode);
    chk("no_valid_on_mode_change", 32'(hue_valid), 0);
    chk("hue_on_mode_change", 32'(hue_angle), tb_hue);
    cur_mode  = new_mode;
    next_step = m + n_of(new_mode);
    idle(10);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    while (exp_q.size() > 0 && exp_q[0].edge_no < cyc) begin
      n_vec++;
      n_err++;
      $display("FAIL missed_step: expected hue %0d at edge %0d, no hue_valid seen",
               exp_q[0].hue, exp_q[0].edge_no);
      void'(exp_q.pop_front());
    end
    if (hue_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_valid @edge %0d: hue_angle=%0d, no step expected", cyc, hue_angle);
      end else begin
        e = exp_q.pop_front();
        chk("step_edge", cyc, e.edge_no);
        chk("step_hue", 32'(hue_angle), e.hue);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d vectors, %0d miscompares", n_vec, n_err);
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int unsigned h0;
    int unsigned p;
    int unsigned s200;
    rst_n    = 1'b0;
    btn      = 1'b0;
    tb_hue   = 0;
    cur_mode = 0;
    next_step = 0;

    // Reset state
    wait_edge(2);
    chk("reset_hue", 32'(hue_angle), 0);
    chk("reset_valid", 32'(hue_valid), 0);
    chk("reset_mode", 32'(mode), 0);
    wait_edge(3);
    rst_n     = 1'b1;
    next_step = cyc + 8;

    // Slow run from reset: hues 1,2,3 every 8 cycles
    idle(25);
    chk("mode_run_slow", 32'(mode), 0);

    // Bouncy button: 2-cycle toggles never reach the debounce threshold
    for (int i = 0; i < 20; i++) begin
      btn = ((i % 2) == 0);
      idle(2);
      chk("db_level_during_bounce", 32'(dut.db_level_q), 0);
    end
    btn = 1'b0;
    idle(10);
    chk("mode_after_bounce", 32'(mode), 0);
    chk("db_level_after_bounce", 32'(dut.db_level_q), 0);

    // Mode walk: fast, hold (press on timer==N-1), reverse with wrap, slow, fast
    press(1, 1'b0);
    idle(10);
    press(2, 1'b1);
    h0 = tb_hue;
    chk("hold_hue_start", 32'(hue_angle), h0);
    idle(100);
    chk("hold_hue_end", 32'(hue_angle), h0);
    press(3, 1'b0);
    idle(8 * (tb_hue + 3));
    press(0, 1'b1);
    idle(12);
    press(1, 1'b0);
    idle(2 * (360 - tb_hue) + 4);

    // Reach hue 200 in fast mode, then reset with debounce counter at 3
    while (tb_hue != 200) schedule(next_step + 1);
    s200 = next_step - 2;
    wait_edge(s200 - 5);
    p   = cyc;
    btn = 1'b1;
    wait_edge(p + 5);
    chk("db_cnt_before_reset", 32'(dut.db_cnt_q), 3);
    chk("hue_before_reset", 32'(hue_angle), 200);
    chk("mode_before_reset", 32'(mode), 1);
    rst_n = 1'b0;
    btn   = 1'b0;
    wait_edge(p + 6);
    chk("midrun_reset_hue", 32'(hue_angle), 0);
    chk("midrun_reset_mode", 32'(mode), 0);
    chk("midrun_reset_valid", 32'(hue_valid), 0);
    chk("midrun_reset_db_cnt", 32'(dut.db_cnt_q), 0);
    rst_n     = 1'b1;
    tb_hue    = 0;
    cur_mode  = 0;
    next_step = p + 14;
    idle(26);

    chk("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
